// File: rtl/line_mem_responder_if.sv
// Line memory bus between the L1 cache (master) and a line-wide memory (slave).
// A request is held until the one-cycle resp pulse; rdata is valid with resp.
interface line_mem_if;
  logic         read;
  logic         write;
  logic [15:0]  address;
  logic [127:0] wdata;
  logic         resp;
  logic [127:0] rdata;
  logic         err;

  modport master (
    output read, write, address, wdata,
    input  resp, rdata, err
  );

  modport slave (
    input  read, write, address, wdata,
    output resp, rdata, err
  );
endinterface

// File: rtl/line_mem_responder.sv
// Line-wide RAM that answers each cache line request after DELAY cycles.
// Optional protocol checker enabled by defining LINE_MEM_PROTOCOL_CHECK_EN.
module line_mem_responder #(
  parameter int DELAY     = 5,
  parameter int LINE_BITS = 12
) (
  input logic     clk,
  input logic     rst,
  line_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] CNT_INIT = 8'(DELAY - 1);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   op_write_q, op_write_d;
  logic [LINE_BITS-1:0]   idx_q, idx_d;
  logic [127:0]           wdata_q, wdata_d;
  logic [127:0]           rdata_q, rdata_d;
  logic [LINE_BITS-1:0]   req_idx;
  logic                   ram_we;
  logic                   addr_unused;
  logic [127:0]           ram [2**LINE_BITS];

  // Byte offset is ignored and line indices above the depth wrap.
  assign req_idx     = bus.address[4 +: LINE_BITS];
  assign addr_unused = ^bus.address;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ram_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.read || bus.write) begin
          op_write_d = bus.write;
          idx_d      = req_idx;
          wdata_d    = bus.wdata;
          cnt_d      = CNT_INIT;
          state_d    = (DELAY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = RESP;
      end
      RESP: begin
        ram_we  = op_write_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Read data is captured as the FSM enters RESP, using the index being latched.
    if (state_d == RESP && state_q != RESP && !op_write_d)
      rdata_d = ram[idx_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    op_write_q <= op_write_d;
    idx_q      <= idx_d;
    wdata_q    <= wdata_d;
  end

  // A reset landing in the RESP cycle aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) ram[idx_q] <= wdata_q;
  end

  assign bus.resp  = (state_q == RESP);
  assign bus.rdata = rdata_q;

`ifdef LINE_MEM_PROTOCOL_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.read && bus.write) err_d = 1'b1;
    if (state_q != IDLE && (bus.read || bus.write) &&
        (req_idx != idx_q || bus.write != op_write_q))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: a DELAY=5 instance for directed cases and a
// DELAY=1 instance for randomized traffic, both against a line-array model.
module tb_line_mem_responder;

`ifdef LINE_MEM_PROTOCOL_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0, rst1;
  logic         rd_i [2];
  logic         wr_i [2];
  logic [15:0]  ad_i [2];
  logic [127:0] wd_i [2];

  line_mem_if if0 ();
  line_mem_if if1 ();

  assign if0.read    = rd_i[0];
  assign if0.write   = wr_i[0];
  assign if0.address = ad_i[0];
  assign if0.wdata   = wd_i[0];
  assign if1.read    = rd_i[1];
  assign if1.write   = wr_i[1];
  assign if1.address = ad_i[1];
  assign if1.wdata   = wd_i[1];

  line_mem_responder #(.DELAY(5), .LINE_BITS(12)) dut5 (.clk(clk), .rst(rst0), .bus(if0.slave));
  line_mem_responder #(.DELAY(1), .LINE_BITS(12)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  bit [127:0] mdl [2][4096];
  bit [127:0] last_rd [2];
  int         lines [8];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_resp(input int s);
    return (s == 0) ? if0.resp : if1.resp;
  endfunction

  function automatic logic [127:0] get_rdata(input int s);
    return (s == 0) ? if0.rdata : if1.rdata;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction, started in the cycle right after the previous resp (or idle).
  task automatic op(input int s, input bit r, input bit w, input logic [15:0] a,
                    input logic [127:0] d, input bit chg, input logic [15:0] a2);
    int dly;
    int k;
    int idx;
    dly = (s == 0) ? 5 : 1;
    idx = int'(a[15:4]);
    rd_i[s] = r;
    wr_i[s] = w;
    ad_i[s] = a;
    wd_i[s] = d;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (chg && k == 2) ad_i[s] = a2;
    end while (!get_resp(s) && k < 300);
    chk("latency", 128'(k), 128'(dly));
    rd_i[s] = 1'b0;
    wr_i[s] = 1'b0;
    if (w) begin
      mdl[s][idx] = d;
      chk("rdata_hold_on_write", get_rdata(s), last_rd[s]);
    end else begin
      chk("rdata", get_rdata(s), mdl[s][idx]);
      last_rd[s] = mdl[s][idx];
    end
    @(posedge clk); #1;
    chk("resp_width", 128'(get_resp(s)), 128'(0));
  endtask

  initial begin
    logic [127:0] line_a;
    int g;
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_i[i] = 1'b0; wr_i[i] = 1'b0; ad_i[i] = '0; wd_i[i] = '0;
      last_rd[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp0",  128'(if0.resp), 128'(0));
    chk("rst_rdata0", if0.rdata, 128'(0));
    chk("rst_err0",   128'(if0.err), 128'(0));
    chk("rst_resp1",  128'(if1.resp), 128'(0));
    chk("rst_rdata1", if1.rdata, 128'(0));
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(posedge clk); #1;

    // Write then read one line
    op(0, 0, 1, 16'h0120, 128'hDEAD_C0DE_0123_4567_89AB_CDEF_FACE_BEEF, 0, 16'h0);
    op(0, 1, 0, 16'h0120, '0, 0, 16'h0);

    // Back-to-back read-after-write, then another byte address in the same line
    op(0, 0, 1, 16'h0040, rnd128(), 0, 16'h0);
    op(0, 1, 0, 16'h0040, '0, 0, 16'h0);
    op(0, 1, 0, 16'h004F, '0, 0, 16'h0);
    chk("err_clean", 128'(if0.err), 128'(0));

    // Address changed while busy: latched line wins
    op(0, 0, 1, 16'h0100, rnd128(), 0, 16'h0);
    op(0, 0, 1, 16'h0200, rnd128(), 0, 16'h0);
    op(0, 1, 0, 16'h0100, '0, 1, 16'h0200);
    chk("err_addr_change", 128'(if0.err), 128'(CHK));

    // read and write together act as a write
    op(0, 1, 1, 16'h0300, 128'h5, 0, 16'h0);
    op(0, 1, 0, 16'h0300, '0, 0, 16'h0);
    chk("rw_line", last_rd[0], 128'h5);
    chk("err_rw", 128'(if0.err), 128'(CHK));

    // Reset mid-write aborts it
    line_a = rnd128();
    op(0, 0, 1, 16'h0500, line_a, 0, 16'h0);
    wr_i[0] = 1'b1;
    ad_i[0] = 16'h0500;
    wd_i[0] = ~line_a;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst0    = 1'b1;
    wr_i[0] = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b0;
    chk("abort_rdata", if0.rdata, 128'(0));
    chk("abort_err",   128'(if0.err), 128'(0));
    last_rd[0] = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_resp", 128'(if0.resp), 128'(0));
    end
    op(0, 1, 0, 16'h0500, '0, 0, 16'h0);
    chk("abort_kept_old", last_rd[0], line_a);

    // DELAY=1 instance: seed a few lines, then random traffic
    for (int i = 0; i < 8; i++) begin
      lines[i] = (i * 517 + 3) % 4096;
      op(1, 0, 1, {lines[i][11:0], 4'($urandom)}, rnd128(), 0, 16'h0);
    end
    for (int n = 0; n < 100; n++) begin
      int li;
      bit w;
      li = $urandom_range(0, 7);
      w  = 1'($urandom);
      op(1, !w, w, {lines[li][11:0], 4'($urandom)}, rnd128(), 0, 16'h0);
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk); #1;
      end
    end
    chk("err_dly1", 128'(if1.err), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
